// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared opcode encoding and instruction field positions for
//               the SIMD multiply-accumulate block.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Opcode carried in instruction[1:0]
    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_SAT = 2'b11
    } op_e;

    localparam int   c_insn_w     = 3;
    localparam int   c_mode_bit   = 2;     // 0 = full width, 1 = split lanes
    localparam logic c_mode_full  = 1'b0;
    localparam logic c_mode_split = 1'b1;

endpackage
`default_nettype wire

// File: rtl/simd_mac_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_mac_acc_if
// Description : Instruction/operand bus and result bus of simd_mac_acc.
//               master: stall, in_valid, instruction, multiplier, multiplicand
//                       out; result, protect, ovf, out_valid in.
//               slave : the mirror image, used by the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_mac_acc_if
    import mac_pkg::*;
#(
    parameter int W     = 16,
    parameter int SPLIT = 2,
    parameter int GUARD = 8
);
    logic                stall;
    logic                in_valid;
    logic [c_insn_w-1:0] instruction;
    logic [W-1:0]        multiplier;
    logic [W-1:0]        multiplicand;
    logic [2*W-1:0]      result;
    logic [GUARD-1:0]    protect;
    logic [SPLIT-1:0]    ovf;
    logic                out_valid;

    modport master (
        output stall, in_valid, instruction, multiplier, multiplicand,
        input  result, protect, ovf, out_valid
    );

    modport slave (
        input  stall, in_valid, instruction, multiplier, multiplicand,
        output result, protect, ovf, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane
// Description : Combinational next-value logic for one accumulator lane:
//               signed OWxOW multiply, sign-extended load or wrapping add,
//               and saturation of the low part with guard-bit extension.
//   a_i, b_i   : signed operands (OW bits)
//   acc_i      : current lane value {guard, low} (2*OW+GW bits)
//   op_i       : opcode; restart_i turns MAC into MUL
//   acc_o      : next lane value; sat_o : lane was clamped by SAT
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane
    import mac_pkg::*;
#(
    parameter int OW = 8,
    parameter int GW = 4
) (
    input  logic signed [OW-1:0]      a_i,
    input  logic signed [OW-1:0]      b_i,
    input  logic [2*OW+GW-1:0]        acc_i,
    input  op_e                       op_i,
    input  logic                      restart_i,
    output logic [2*OW+GW-1:0]        acc_o,
    output logic                      sat_o
);
    localparam int c_lw = 2 * OW;
    localparam int c_aw = 2 * OW + GW;

    logic signed [c_lw-1:0] w_a_ext;
    logic signed [c_lw-1:0] w_b_ext;
    logic signed [c_lw-1:0] w_prod;
    logic [c_aw-1:0]        w_prod_ext;
    logic                   w_in_range;
    logic [c_aw-1:0]        w_max;
    logic [c_aw-1:0]        w_min;

    assign w_a_ext    = {{OW{a_i[OW-1]}}, a_i};
    assign w_b_ext    = {{OW{b_i[OW-1]}}, b_i};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{GW{w_prod[c_lw-1]}}, w_prod};

    // Value fits the signed low part when the guard bits all repeat the
    // low part's sign bit.
    assign w_in_range = (&acc_i[c_aw-1:c_lw-1]) | ~(|acc_i[c_aw-1:c_lw-1]);
    assign w_max      = {{(GW+1){1'b0}}, {(c_lw-1){1'b1}}};
    assign w_min      = {{(GW+1){1'b1}}, {(c_lw-1){1'b0}}};

    always_comb begin
        acc_o = acc_i;
        sat_o = 1'b0;
        case (op_i)
            OP_CLR: acc_o = '0;
            OP_MUL: acc_o = w_prod_ext;
            OP_MAC: acc_o = restart_i ? w_prod_ext : acc_i + w_prod_ext;
            OP_SAT: begin
                if (!w_in_range) begin
                    sat_o = 1'b1;
                    acc_o = acc_i[c_aw-1] ? w_min : w_max;
                end
            end
            default: acc_o = acc_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/simd_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : simd_mac_acc
// Description : 3-stage SIMD multiply-accumulate. Stage 1 captures the
//               instruction, stage 2 updates the 2W+GUARD accumulator (full
//               width or SPLIT independent lanes), stage 3 registers the
//               accumulator image onto result/protect/ovf.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of simd_mac_acc_if (operands in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module simd_mac_acc
    import mac_pkg::*;
#(
    parameter int W     = 16,
    parameter int SPLIT = 2,
    parameter int GUARD = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    simd_mac_acc_if.slave bus
);
    localparam int c_aw = 2 * W + GUARD;
    localparam int c_ow = W / SPLIT;
    localparam int c_lw = 2 * W / SPLIT;
    localparam int c_gl = GUARD / SPLIT;

    // Stage 1: captured instruction
    logic                v1_q;
    logic [c_insn_w-1:0] ins1_q;
    logic [W-1:0]        a1_q, b1_q;

    // Stage 2: accumulator, kept as low part and guard part
    logic                v2_q;
    logic [2*W-1:0]      res_q, res_d;
    logic [GUARD-1:0]    prot_q, prot_d;
    logic [SPLIT-1:0]    ovf_q, ovf_d;
    logic                last_mode_q, last_mode_d;

    // Stage 3: output registers
    logic                out_valid_q;
    logic [2*W-1:0]      result_q;
    logic [GUARD-1:0]    protect_q;
    logic [SPLIT-1:0]    ovf_out_q;

    op_e  w_op;
    logic w_mode;
    logic w_restart;

    assign w_op      = op_e'(ins1_q[1:0]);
    assign w_mode    = ins1_q[c_mode_bit];
    // A MAC in a different mode than the last MUL/MAC starts afresh.
    assign w_restart = (w_op == OP_MAC) && (w_mode != last_mode_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            ins1_q <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
        end else if (!bus.stall) begin
            v1_q   <= bus.in_valid;
            ins1_q <= bus.instruction;
            a1_q   <= bus.multiplier;
            b1_q   <= bus.multiplicand;
        end
    end

    // Full-width datapath
    logic [c_aw-1:0] w_full_acc;
    logic            w_full_sat;

    mac_lane #(.OW(W), .GW(GUARD)) u_full (
        .a_i       (a1_q),
        .b_i       (b1_q),
        .acc_i     ({prot_q, res_q}),
        .op_i      (w_op),
        .restart_i (w_restart),
        .acc_o     (w_full_acc),
        .sat_o     (w_full_sat)
    );

    // Split datapath: lane i uses low bits res[i] and guard bits prot[i]
    logic [2*W-1:0]   w_split_res;
    logic [GUARD-1:0] w_split_prot;
    logic [SPLIT-1:0] w_split_sat;

    genvar gi;
    generate
        for (gi = 0; gi < SPLIT; gi++) begin : g_lane
            logic [c_lw+c_gl-1:0] w_lane_acc;

            mac_lane #(.OW(c_ow), .GW(c_gl)) u_lane (
                .a_i       (a1_q[gi*c_ow +: c_ow]),
                .b_i       (b1_q[gi*c_ow +: c_ow]),
                .acc_i     ({prot_q[gi*c_gl +: c_gl], res_q[gi*c_lw +: c_lw]}),
                .op_i      (w_op),
                .restart_i (w_restart),
                .acc_o     (w_lane_acc),
                .sat_o     (w_split_sat[gi])
            );

            assign w_split_res[gi*c_lw +: c_lw]  = w_lane_acc[c_lw-1:0];
            assign w_split_prot[gi*c_gl +: c_gl] = w_lane_acc[c_lw +: c_gl];
        end
    endgenerate

    always_comb begin
        res_d       = res_q;
        prot_d      = prot_q;
        ovf_d       = ovf_q;
        last_mode_d = last_mode_q;
        if (v1_q) begin
            if (w_op == OP_CLR) begin
                res_d  = '0;
                prot_d = '0;
                ovf_d  = '0;
            end else if (w_mode == c_mode_split) begin
                res_d  = w_split_res;
                prot_d = w_split_prot;
                ovf_d  = ovf_q | w_split_sat;
            end else begin
                res_d  = w_full_acc[2*W-1:0];
                prot_d = w_full_acc[c_aw-1:2*W];
                ovf_d  = ovf_q | SPLIT'(w_full_sat);
            end
            if ((w_op == OP_MUL) || (w_op == OP_MAC)) begin
                last_mode_d = w_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q        <= 1'b0;
            res_q       <= '0;
            prot_q      <= '0;
            ovf_q       <= '0;
            last_mode_q <= c_mode_full;
        end else if (!bus.stall) begin
            v2_q        <= v1_q;
            res_q       <= res_d;
            prot_q      <= prot_d;
            ovf_q       <= ovf_d;
            last_mode_q <= last_mode_d;
        end
    end

    // Outputs hold their last valid image across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            protect_q   <= '0;
            ovf_out_q   <= '0;
        end else if (!bus.stall) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                result_q  <= res_q;
                protect_q <= prot_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.protect   = protect_q;
    assign bus.ovf       = ovf_out_q;
    assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_simd_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_mac_acc
// Description : Self-checking bench for simd_mac_acc (W=16, SPLIT=2, GUARD=8)
//               with an arithmetic lane model and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_mac_acc;
    import mac_pkg::*;

    localparam int W     = 16;
    localparam int SPLIT = 2;
    localparam int GUARD = 8;
    localparam int AW    = 2 * W + GUARD;

    typedef struct {
        int               cyc;
        logic [2*W-1:0]   res;
        logic [GUARD-1:0] prot;
        logic [SPLIT-1:0] ovf;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   nt = 0;
    int   nf = 0;
    int   adv = 0;
    int   prev_adv = 0;
    logic stalled_edge = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    logic [AW-1:0]    m_acc  = '0;
    logic [SPLIT-1:0] m_ovf  = '0;
    logic             m_last = 1'b0;

    // Output snapshot from the previous falling edge
    logic [2*W-1:0]   s_res;
    logic [GUARD-1:0] s_prot;
    logic [SPLIT-1:0] s_ovf;
    logic             s_ov;

    simd_mac_acc_if #(.W(W), .SPLIT(SPLIT), .GUARD(GUARD)) bus ();

    simd_mac_acc #(.W(W), .SPLIT(SPLIT), .GUARD(GUARD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic [2:0] mk(input logic m, input op_e o);
        return {m, o};
    endfunction

    // Behavioural model: each lane is a signed integer of lw+gl bits.
    task automatic model_exec(input logic [2:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
        int   n, ow, lw, gl;
        logic mode;
        logic [1:0] op;
        longint v, av, bv, p, nv, hi, lo;
        mode = ins[2];
        op   = ins[1:0];
        if (op == 2'b00) begin
            m_acc = '0;
            m_ovf = '0;
        end else begin
            n  = mode ? SPLIT : 1;
            ow = W / n;
            lw = 2 * W / n;
            gl = GUARD / n;
            for (int i = 0; i < n; i++) begin
                v = 0; av = 0; bv = 0;
                for (int j = 0; j < lw; j++) v[j] = m_acc[i*lw + j];
                for (int j = 0; j < gl; j++) v[lw + j] = m_acc[2*W + i*gl + j];
                v = sx(v, lw + gl);
                for (int j = 0; j < ow; j++) begin
                    av[j] = a[i*ow + j];
                    bv[j] = b[i*ow + j];
                end
                p  = sx(av, ow) * sx(bv, ow);
                hi = (longint'(1) <<< (lw - 1)) - 1;
                lo = -hi - 1;
                nv = v;
                if (op == 2'b01) nv = p;
                else if (op == 2'b10) nv = (mode != m_last) ? p : v + p;
                else begin
                    if (v > hi) begin nv = hi; m_ovf[i] = 1'b1; end
                    else if (v < lo) begin nv = lo; m_ovf[i] = 1'b1; end
                end
                for (int j = 0; j < lw; j++) m_acc[i*lw + j] = nv[j];
                for (int j = 0; j < gl; j++) m_acc[2*W + i*gl + j] = nv[lw + j];
            end
            if (op == 2'b01 || op == 2'b10) m_last = mode;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] ins, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic st);
        exp_t e;
        @(negedge clk);
        bus.stall        = st;
        bus.in_valid     = v;
        bus.instruction  = ins;
        bus.multiplier   = a;
        bus.multiplicand = b;
        if (v && !st) begin
            model_exec(ins, a, b);
            e.cyc  = adv + 3;
            e.res  = m_acc[2*W-1:0];
            e.prot = m_acc[AW-1:2*W];
            e.ovf  = m_ovf;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_n && !bus.stall) adv <= adv + 1;
        stalled_edge <= reset_n && bus.stall;
    end

    // Monitor: every advancing edge either delivers the due entry or shows
    // out_valid low; stalled edges must leave every output untouched.
    always @(negedge clk) begin
        if (reset_n) begin
            if (adv != prev_adv) begin
                if (sb.size() > 0 && sb[0].cyc == adv) begin
                    mon_e = sb.pop_front();
                    chk("out_valid", 64'(bus.out_valid), 64'd1);
                    chk("result",    64'(bus.result),    64'(mon_e.res));
                    chk("protect",   64'(bus.protect),   64'(mon_e.prot));
                    chk("ovf",       64'(bus.ovf),       64'(mon_e.ovf));
                end else begin
                    chk("idle_slot_out_valid", 64'(bus.out_valid), 64'd0);
                end
            end else if (stalled_edge) begin
                chk("stall_result",    64'(bus.result),    64'(s_res));
                chk("stall_protect",   64'(bus.protect),   64'(s_prot));
                chk("stall_ovf",       64'(bus.ovf),       64'(s_ovf));
                chk("stall_out_valid", 64'(bus.out_valid), 64'(s_ov));
            end
        end
        prev_adv = adv;
        s_res    = bus.result;
        s_prot   = bus.protect;
        s_ovf    = bus.ovf;
        s_ov     = bus.out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.stall = 1'b0; bus.in_valid = 1'b0; bus.instruction = '0;
        bus.multiplier = '0; bus.multiplicand = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_protect",   64'(bus.protect),   64'd0);
        chk("rst_ovf",       64'(bus.ovf),       64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Full-width product at the positive corner
        drive(1'b1, mk(1'b0, OP_MUL), 16'h7FFF, 16'h7FFF, 1'b0);
        drain();
        chk("full_mul_result",  64'(bus.result),  64'h3FFF0001);
        chk("full_mul_protect", 64'(bus.protect), 64'h00);

        // Accumulate into the guard range, then saturate
        drive(1'b1, mk(1'b0, OP_MUL), 16'h8000, 16'h8000, 1'b0);
        drive(1'b1, mk(1'b0, OP_MAC), 16'h8000, 16'h8000, 1'b0);
        drive(1'b1, mk(1'b0, OP_MAC), 16'h8000, 16'h8000, 1'b0);
        drain();
        chk("full_mac_result",  64'(bus.result),  64'hC0000000);
        chk("full_mac_protect", 64'(bus.protect), 64'h00);
        drive(1'b1, mk(1'b0, OP_SAT), 16'h0, 16'h0, 1'b0);
        drain();
        chk("sat_result",  64'(bus.result),  64'h7FFFFFFF);
        chk("sat_protect", 64'(bus.protect), 64'h00);
        chk("sat_ovf",     64'(bus.ovf),     64'h1);

        // Split product, lanes +127^2 and (-128)^2
        drive(1'b1, mk(1'b1, OP_CLR), 16'h0, 16'h0, 1'b0);
        drive(1'b1, mk(1'b1, OP_MUL), 16'h7F80, 16'h7F80, 1'b0);
        drain();
        chk("split_mul_result",  64'(bus.result),  64'h3F014000);
        chk("split_mul_protect", 64'(bus.protect), 64'h00);

        // Split MAC stream with a 3-cycle stall in the middle
        drive(1'b1, mk(1'b1, OP_MUL), pick(), pick(), 1'b0);
        drive(1'b1, mk(1'b1, OP_MAC), pick(), pick(), 1'b0);
        drive(1'b1, mk(1'b1, OP_MAC), pick(), pick(), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, mk(1'b1, OP_MAC), pick(), pick(), 1'b1);
        drive(1'b1, mk(1'b1, OP_MAC), pick(), pick(), 1'b0);
        drive(1'b1, mk(1'b1, OP_MAC), pick(), pick(), 1'b0);
        drain();
        chk("stall_final_result", 64'(bus.result), 64'(m_acc[2*W-1:0]));

        // Split lanes wrap modulo 20 bits without carrying across lanes
        drive(1'b1, mk(1'b1, OP_MUL), 16'h8080, 16'h8080, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, mk(1'b1, OP_MAC), 16'h8080, 16'h8080, 1'b0);
        drain();

        // Reset while a MAC is in flight
        drive(1'b1, mk(1'b1, OP_MAC), 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_result",    64'(bus.result),    64'd0);
        chk("midrst_protect",   64'(bus.protect),   64'd0);
        chk("midrst_ovf",       64'(bus.ovf),       64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        sb.delete();
        m_acc = '0; m_ovf = '0; m_last = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle();
        drive(1'b1, mk(1'b0, OP_MUL), 16'h0003, 16'hFFFB, 1'b0);
        drain();

        // Bubble between MACs, drive lanes into saturation, then CLR
        drive(1'b1, mk(1'b1, OP_MUL), 16'h7F7F, 16'h7F7F, 1'b0);
        drive(1'b1, mk(1'b1, OP_MAC), 16'h7F7F, 16'h7F7F, 1'b0);
        idle();
        drive(1'b1, mk(1'b1, OP_MAC), 16'h7F7F, 16'h7F7F, 1'b0);
        drive(1'b1, mk(1'b1, OP_MAC), 16'h7F7F, 16'h7F7F, 1'b0);
        drive(1'b1, mk(1'b1, OP_SAT), 16'h0, 16'h0, 1'b0);
        drain();
        chk("bubble_sat_ovf", 64'(bus.ovf), 64'h3);
        drive(1'b1, mk(1'b0, OP_CLR), 16'h0, 16'h0, 1'b0);
        drain();
        chk("clr_ovf", 64'(bus.ovf), 64'h0);

        // Random traffic: mixed modes, bubbles and stalls
        for (int k = 0; k < 300; k++) begin
            int   o;
            op_e  op;
            o  = int'($urandom_range(0, 9));
            op = (o == 0) ? OP_CLR : (o < 4) ? OP_MUL : (o < 9) ? OP_MAC : OP_SAT;
            drive(($urandom_range(0, 6) != 0), mk(1'($urandom_range(0, 1)), op),
                  pick(), pick(), ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
`default_nettype wire
